// File: rtl/lp_power_ctrl.sv
// Power/clock controller for the low-power calculator: round-robin request
// arbitration plus an ACTIVE/IDLE/SLEEP/DEEP/WAKE sequencer driving gate enables.
module lp_power_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int IDLE_TIMEOUT = 8,
    parameter int DEEP_TIMEOUT = 64,
    parameter int WAKE_CYCLES  = 4,
    parameter int CNT_W        = 8,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] event_req,
    input  logic              compute_done,
    output logic [NUM_CH-1:0] event_ack,
    output logic [CH_W-1:0]   ch_sel,
    output logic              clk_en,
    output logic              compute_en,
    output logic              pwr_en,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_SLEEP  = 3'd0,
        S_ACTIVE = 3'd1,
        S_IDLE   = 3'd2,
        S_WAKE   = 3'd3,
        S_DEEP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DEEP_LAST = CNT_W'(DEEP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   last_grant, grant, idx;
    logic              any_req, found;

    assign any_req = |event_req;
    assign state_o = state;

    // Round-robin search starting one past the previous winner, wrapping.
    always_comb begin
        grant = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CH_W'((int'(last_grant) + i) % NUM_CH);
            if (!found && event_req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // A request always beats a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SLEEP: begin
                if (any_req)                state_nxt = S_ACTIVE;
                else if (cnt == DEEP_LAST)  state_nxt = S_DEEP;
            end
            S_DEEP: begin
                if (any_req)                state_nxt = S_WAKE;
            end
            S_WAKE: begin
                if (cnt == WAKE_LAST)       state_nxt = any_req ? S_ACTIVE : S_IDLE;
            end
            S_ACTIVE: begin
                if (compute_done)           state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (any_req)                state_nxt = S_ACTIVE;
                else if (cnt == IDLE_LAST)  state_nxt = S_SLEEP;
            end
            default:                        state_nxt = S_SLEEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_SLEEP;
            cnt        <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            ch_sel     <= '0;
            clk_en     <= 1'b0;
            compute_en <= 1'b0;
            pwr_en     <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (!(&cnt))
                cnt <= cnt + 1'b1;
            if (state_nxt == S_ACTIVE && state != S_ACTIVE) begin
                ch_sel     <= grant;
                last_grant <= grant;
            end
            // Enables are decoded from the next state so they align with state.
            pwr_en     <= (state_nxt != S_DEEP);
            clk_en     <= (state_nxt == S_ACTIVE) || (state_nxt == S_IDLE);
            compute_en <= (state_nxt == S_ACTIVE);
        end
    end

    always_comb begin
        event_ack = '0;
        if (state == S_ACTIVE && compute_done)
            event_ack[ch_sel] = 1'b1;
    end

endmodule

// File: tb/tb_lp_power_ctrl.sv
// Directed bench for lp_power_ctrl: a per-cycle reference model plus
// hand-computed literal checks on the documented scenarios.
module tb_lp_power_ctrl;

    localparam int NUM_CH = 4;
    localparam int IDLE_T = 8;
    localparam int DEEP_T = 64;
    localparam int WAKE_T = 4;
    localparam int M_SLEEP = 0, M_ACTIVE = 1, M_IDLE = 2, M_WAKE = 3, M_DEEP = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] event_req;
    logic              compute_done;
    logic [NUM_CH-1:0] event_ack;
    logic [1:0]        ch_sel;
    logic              clk_en, compute_en, pwr_en;
    logic [2:0]        state_o;

    int vectors = 0;
    int miscompares = 0;

    lp_power_ctrl #(
        .NUM_CH(NUM_CH), .IDLE_TIMEOUT(IDLE_T), .DEEP_TIMEOUT(DEEP_T),
        .WAKE_CYCLES(WAKE_T), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .event_req(event_req), .compute_done(compute_done),
        .event_ack(event_ack), .ch_sel(ch_sel), .clk_en(clk_en),
        .compute_en(compute_en), .pwr_en(pwr_en), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: phase of operation, time spent in it, and the last winner.
    int m_state, m_time, m_last, m_ch;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int nxt;
        if (reset) begin
            m_state = M_SLEEP; m_time = 0; m_last = NUM_CH - 1; m_ch = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            nxt = m_state;
            if (m_state == M_SLEEP)
                nxt = (event_req != 0) ? M_ACTIVE : (m_time + 1 == DEEP_T) ? M_DEEP : M_SLEEP;
            else if (m_state == M_DEEP)
                nxt = (event_req != 0) ? M_WAKE : M_DEEP;
            else if (m_state == M_WAKE)
                nxt = (m_time + 1 < WAKE_T) ? M_WAKE : (event_req != 0) ? M_ACTIVE : M_IDLE;
            else if (m_state == M_ACTIVE)
                nxt = compute_done ? M_IDLE : M_ACTIVE;
            else
                nxt = (event_req != 0) ? M_ACTIVE : (m_time + 1 == IDLE_T) ? M_SLEEP : M_IDLE;
            if (nxt == M_ACTIVE && m_state != M_ACTIVE) begin
                for (int k = NUM_CH; k >= 1; k--)
                    if (event_req[(m_last + k) % NUM_CH]) m_ch = (m_last + k) % NUM_CH;
                m_last = m_ch;
            end
            m_time  = (nxt == m_state) ? m_time + 1 : 0;
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        int e_pwr, e_clk, e_cmp, e_ack;
        if (m_valid) begin
            e_pwr = (m_state != M_DEEP);
            e_clk = (m_state == M_ACTIVE || m_state == M_IDLE);
            e_cmp = (m_state == M_ACTIVE);
            e_ack = (m_state == M_ACTIVE && compute_done) ? (1 << m_ch) : 0;
            vectors++;
            if (state_o != m_state || pwr_en != e_pwr || clk_en != e_clk ||
                compute_en != e_cmp || event_ack != e_ack ||
                (e_cmp && ch_sel != m_ch)) begin
                miscompares++;
                $display("FAIL model t=%0t: got st=%0d pwr=%0d clk=%0d cmp=%0d ack=%b ch=%0d, expected st=%0d pwr=%0d clk=%0d cmp=%0d ack=%0d ch=%0d",
                         $time, state_o, pwr_en, clk_en, compute_en, event_ack, ch_sel,
                         m_state, e_pwr, e_clk, e_cmp, e_ack, m_ch);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (state_o != s && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", state_o, s);
    endtask

    task automatic count_in(input string name, input int s, input int exp);
        int n = 1;
        while (state_o == s && n < 300) begin
            tick();
            if (state_o == s) n++;
        end
        chk(name, n, exp);
    endtask

    task automatic serve(input string name, input int ch);
        compute_done = 1'b1;
        #1;
        chk({name, "_ack"}, event_ack, 1 << ch);
        tick();
        compute_done = 1'b0;
        event_req = '0;
        chk({name, "_idle"}, state_o, M_IDLE);
    endtask

    initial begin
        reset = 1'b1; event_req = '0; compute_done = 1'b0;
        tick(); tick();
        chk("rst_state", state_o, M_SLEEP);
        chk("rst_pwr", pwr_en, 1);
        chk("rst_clk", clk_en, 0);
        chk("rst_cmp", compute_en, 0);
        chk("rst_ack", event_ack, 0);
        chk("rst_ch", ch_sel, 0);
        reset = 1'b0;

        // Single request from SLEEP, then idle down to DEEP and wake.
        event_req = 4'b0001;
        tick();
        chk("sleep_wake_state", state_o, M_ACTIVE);
        chk("sleep_wake_ch", ch_sel, 0);
        tick(); tick();
        serve("op0", 0);
        count_in("idle_len", M_IDLE, IDLE_T);
        count_in("sleep_len", M_SLEEP, DEEP_T);
        chk("deep_state", state_o, M_DEEP);
        chk("deep_pwr", pwr_en, 0);
        event_req = 4'b0010;
        tick();
        chk("wake_state", state_o, M_WAKE);
        chk("wake_pwr", pwr_en, 1);
        chk("wake_clk", clk_en, 0);
        count_in("wake_len", M_WAKE, WAKE_T);
        chk("wake_active", state_o, M_ACTIVE);
        chk("wake_ch", ch_sel, 1);
        serve("op1", 1);

        // All channels held: round-robin from reset.
        reset = 1'b1; tick(); reset = 1'b0;
        event_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_active", state_o, M_ACTIVE);
            chk("rr_ch", ch_sel, k % 4);
            compute_done = 1'b1;
            #1;
            chk("rr_ack", event_ack, 1 << (k % 4));
            tick();
            compute_done = 1'b0;
            chk("rr_idle", state_o, M_IDLE);
        end
        event_req = '0;

        // Request coincides with IDLE and SLEEP timeouts.
        repeat (IDLE_T - 1) tick();
        event_req = 4'b0100;
        tick();
        chk("idle_race", state_o, M_ACTIVE);
        chk("idle_race_ch", ch_sel, 2);
        serve("op2", 2);
        repeat (IDLE_T) tick();
        chk("to_sleep", state_o, M_SLEEP);
        repeat (DEEP_T - 1) tick();
        event_req = 4'b1000;
        tick();
        chk("sleep_race", state_o, M_ACTIVE);
        chk("sleep_race_ch", ch_sel, 3);
        serve("op3", 3);

        // Reset during WAKE and during ACTIVE.
        wait_state(M_DEEP, 200);
        event_req = 4'b0001;
        tick();
        chk("rw_wake", state_o, M_WAKE);
        tick();
        reset = 1'b1;
        tick();
        chk("rw_state", state_o, M_SLEEP);
        chk("rw_pwr", pwr_en, 1);
        chk("rw_clk", clk_en, 0);
        chk("rw_ack", event_ack, 0);
        reset = 1'b0;
        tick();
        chk("rw_ch", ch_sel, 0);
        event_req = 4'b0010;
        reset = 1'b1;
        tick();
        chk("ra_state", state_o, M_SLEEP);
        chk("ra_ack", event_ack, 0);
        chk("ra_cmp", compute_en, 0);
        reset = 1'b0;
        event_req = 4'b0011;
        tick();
        chk("ra_active", state_o, M_ACTIVE);
        chk("ra_ch", ch_sel, 0);
        serve("op4", 0);

        // Request withdrawn during WAKE.
        wait_state(M_DEEP, 200);
        event_req = 4'b0001;
        tick();
        chk("wd_wake", state_o, M_WAKE);
        event_req = '0;
        repeat (WAKE_T) tick();
        chk("wd_idle", state_o, M_IDLE);
        count_in("wd_idle_len", M_IDLE, IDLE_T);
        chk("wd_sleep", state_o, M_SLEEP);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lp_power_ctrl.md
# lp_power_ctrl

Parametrised multi-channel power/clock controller for the low-power calculator. It arbitrates up to NUM_CH requesters round-robin and drives clock-gate, compute-enable and power-gate controls. It steps through ACTIVE, IDLE, SLEEP and a power-gated DEEP state, with a timed WAKE sequence. It sits between the input event detectors and the gated calculator datapath.

## Interface
- NUM_CH, 4: number of request channels (2..16)
- IDLE_TIMEOUT, 8: cycles spent in IDLE before SLEEP (1..2^CNT_W)
- DEEP_TIMEOUT, 64: cycles spent in SLEEP before DEEP (1..2^CNT_W)
- WAKE_CYCLES, 4: power-up settle cycles in WAKE (1..2^CNT_W)
- CNT_W, 8: width of the shared state-duration counter
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- event_req  in  NUM_CH  per-channel level request; held high until acked
- compute_done  in  1  datapath finished current operation
- event_ack  out  NUM_CH  one-hot ack to the granted channel
- ch_sel  out  $clog2(NUM_CH)  granted channel index, valid while compute_en=1
- clk_en  out  1  datapath clock-gate enable
- compute_en  out  1  datapath operation enable
- pwr_en  out  1  datapath power-rail enable (0 = power-gated)
- state_o  out  3  current state: SLEEP=0, ACTIVE=1, IDLE=2, WAKE=3, DEEP=4

## Operation
- Outputs are Moore decodes of state, except event_ack:
  - DEEP: pwr_en=0, clk_en=0, compute_en=0.
  - WAKE and SLEEP: pwr_en=1, clk_en=0, compute_en=0.
  - ACTIVE: pwr_en=1, clk_en=1, compute_en=1.
  - IDLE: pwr_en=1, clk_en=1, compute_en=0.
- Shared counter cnt:
  - Clears on every state change and on reset.
  - Otherwise increments each cycle, saturating at all-ones.
- any_req = OR of event_req.
- Transitions:
  - SLEEP: any_req -> ACTIVE; else cnt==DEEP_TIMEOUT-1 -> DEEP.
  - DEEP: any_req -> WAKE.
  - WAKE: cnt==WAKE_CYCLES-1 -> ACTIVE if any_req, else IDLE. Requests are ignored before that cycle.
  - ACTIVE: compute_done -> IDLE; otherwise stay. There is no timeout.
  - IDLE: any_req -> ACTIVE; else cnt==IDLE_TIMEOUT-1 -> SLEEP.
  - Illegal encodings -> SLEEP.
- Simultaneous request and timeout in the same cycle: the request wins.
- Arbitration:
  - The grant is computed in the cycle a transition into ACTIVE is taken.
  - It is the first requesting channel searching upward, with wrap, from last_grant+1.
  - The grant is registered into ch_sel and last_grant.
  - ch_sel is stable for the whole ACTIVE stay.
- Ack:
  - event_ack[ch_sel] = (state==ACTIVE) & compute_done. This is combinational, one cycle, one-hot.
  - All other bits are 0.
  - The requester deasserts event_req on the cycle after ack.
- A granted channel that drops its request early is still served until compute_done; no abort.

## Timing
- Reset values:
  - state=SLEEP, cnt=0, last_grant=NUM_CH-1 (so ch0 wins first), ch_sel=0.
  - event_ack=0, clk_en=0, compute_en=0, pwr_en=1, state_o=0.
- Reset asserted mid-operation (any state, including WAKE or ACTIVE) forces these values on the next edge. No ack is issued for the aborted operation.
- SLEEP/IDLE request to compute_en high: 1 cycle.
- DEEP request to compute_en high: 1 + WAKE_CYCLES cycles.
- IDLE lasts exactly IDLE_TIMEOUT cycles when no request arrives. SLEEP lasts exactly DEEP_TIMEOUT cycles when no request arrives.
- Back-to-back: ack in cycle N, IDLE in N+1. A pending request from another channel re-enters ACTIVE in N+2.

## Test plan
- Reset then event_req=4'b0001 in SLEEP -> ACTIVE next cycle, ch_sel=0. compute_done 3 cycles later -> event_ack=4'b0001 for one cycle, then IDLE.
- No requests after an op, defaults -> 8 IDLE cycles, 64 SLEEP cycles, then DEEP with pwr_en=0. Request in DEEP -> 4 WAKE cycles with pwr_en=1, clk_en=0, then ACTIVE.
- All four channels held high continuously -> grants in order 0,1,2,3,0. Each ack is one-hot and matches ch_sel.
- Request arriving in the same cycle cnt hits IDLE_TIMEOUT-1 -> ACTIVE, not SLEEP. Same check for SLEEP at DEEP_TIMEOUT-1 -> ACTIVE, not DEEP.
- Reset pulsed during WAKE and during ACTIVE -> state_o=0, pwr_en=1, clk_en=0, no event_ack. The next grant goes to ch0.
- Request withdrawn during WAKE -> WAKE completes, enters IDLE, times out to SLEEP after IDLE_TIMEOUT cycles.
